mem_arbiter: RTL and testbench

Two-client memory arbiter that shares the core's single memory port between instruction fetch (IFU) and load/store (LSU) once the core moves from single-cycle to multi-cycle operation. It accepts one request at a time, forwards it to the memory port over a valid/ready handshake, and routes the response back to the issuing client. Simultaneous requests are resolved round-robin. The block sits between IFU/LSU and the memory model/bus.

---
 rtl/mem_arbiter_if.sv | 60 ++++++
 rtl/mem_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of the IFU, LSU and memory-port handshakes around mem_arbiter.
// slave = arbiter view, master = the surrounding clients and memory.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [ADDR_W-1:0] ifu_req_addr;
  logic              ifu_resp_valid;
  logic              ifu_resp_ready;
  logic [DATA_W-1:0] ifu_resp_rdata;
  logic              ifu_resp_err;

  logic                 lsu_req_valid;
  logic                lsu_req_ready;
  logic [ADDR_W-1:0]   lsu_req_addr;
  logic                lsu_req_wen;
  logic [DATA_W-1:0]   lsu_req_wdata;
  logic [DATA_W/8-1:0] lsu_req_wmask;
  logic [1:0]          lsu_req_size;
  logic                lsu_resp_valid;
  logic                lsu_resp_ready;
  logic [DATA_W-1:0]   lsu_resp_rdata;
  logic                lsu_resp_err;

  logic                mem_req_valid;
  logic                mem_req_ready;
  logic [ADDR_W-1:0]   mem_req_addr;
  logic                mem_req_wen;
  logic [DATA_W-1:0]   mem_req_wdata;
  logic [DATA_W/8-1:0] mem_req_wmask;
  logic [1:0]          mem_req_size;
  logic                mem_resp_valid;
  logic                mem_resp_ready;
  logic [DATA_W-1:0]   mem_resp_rdata;
  logic                mem_resp_err;

  modport slave (
    input  ifu_req_valid, ifu_req_addr, ifu_resp_ready,
    output ifu_req_ready, ifu_resp_valid, ifu_resp_rdata, ifu_resp_err,
    input  lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
           lsu_req_size, lsu_resp_ready,
    output lsu_req_ready, lsu_resp_valid, lsu_resp_rdata, lsu_resp_err,
    output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
           mem_req_size, mem_resp_ready,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err
  );

  modport master (
    output ifu_req_valid, ifu_req_addr, ifu_resp_ready,
    input  ifu_req_ready, ifu_resp_valid, ifu_resp_rdata, ifu_resp_err,
    output lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
           lsu_req_size, lsu_resp_ready,
    input  lsu_req_ready, lsu_resp_valid, lsu_resp_rdata, lsu_resp_err,
    input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
           mem_req_size, mem_resp_ready,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-client (IFU/LSU) round-robin arbiter for a single memory port.
// One transaction in flight; request payload is registered, response is passed through.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  mem_arbiter_if.slave  bus_io
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;
  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_grant_q, last_grant_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wmask_q, wmask_d;
  logic [1:0]          size_q, size_d;
  logic                grant_ifu, grant_lsu;

  // A tie goes to whichever client was not granted last.
  assign grant_ifu = bus_io.ifu_req_valid &&
                     (!bus_io.lsu_req_valid || last_grant_q == OWN_LSU);
  assign grant_lsu = bus_io.lsu_req_valid && !grant_ifu;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wen_d        = wen_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    size_d       = size_q;
    bus_io.ifu_req_ready  = 1'b0;
    bus_io.lsu_req_ready  = 1'b0;
    bus_io.ifu_resp_valid = 1'b0;
    bus_io.ifu_resp_rdata = '0;
    bus_io.ifu_resp_err   = 1'b0;
    bus_io.lsu_resp_valid = 1'b0;
    bus_io.lsu_resp_rdata = '0;
    bus_io.lsu_resp_err   = 1'b0;
    bus_io.mem_resp_ready = 1'b0;
    case (state_q)
      IDLE: begin
        // Held in reset the arbiter must not hand out readies.
        if (sys_rst) begin
          bus_io.ifu_req_ready = grant_ifu;
          bus_io.lsu_req_ready = grant_lsu;
          if (grant_ifu) begin
            state_d      = REQ;
            owner_d      = OWN_IFU;
            last_grant_d = OWN_IFU;
            addr_d       = bus_io.ifu_req_addr;
            wen_d        = 1'b0;
            wdata_d      = '0;
            wmask_d      = '0;
            size_d       = 2'd2;
          end else if (grant_lsu) begin
            state_d      = REQ;
            owner_d      = OWN_LSU;
            last_grant_d = OWN_LSU;
            addr_d       = bus_io.lsu_req_addr;
            wen_d        = bus_io.lsu_req_wen;
            wdata_d      = bus_io.lsu_req_wdata;
            wmask_d      = bus_io.lsu_req_wmask;
            size_d       = bus_io.lsu_req_size;
          end
        end
      end
      REQ: begin
        if (bus_io.mem_req_ready) state_d = RESP;
      end
      RESP: begin
        if (owner_q == OWN_LSU) begin
          bus_io.lsu_resp_valid = bus_io.mem_resp_valid;
          bus_io.lsu_resp_rdata = bus_io.mem_resp_rdata;
          bus_io.lsu_resp_err   = bus_io.mem_resp_err;
          bus_io.mem_resp_ready = bus_io.lsu_resp_ready;
        end else begin
          bus_io.ifu_resp_valid = bus_io.mem_resp_valid;
          bus_io.ifu_resp_rdata = bus_io.mem_resp_rdata;
          bus_io.ifu_resp_err   = bus_io.mem_resp_err;
          bus_io.mem_resp_ready = bus_io.ifu_resp_ready;
        end
        if (bus_io.mem_resp_valid && bus_io.mem_resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IFU;
      last_grant_q <= OWN_LSU;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      size_q       <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      size_q       <= size_d;
    end
  end

  assign bus_io.mem_req_valid = (state_q == REQ);
  assign bus_io.mem_req_addr  = addr_q;
  assign bus_io.mem_req_wen   = wen_q;
  assign bus_io.mem_req_wdata = wdata_q;
  assign bus_io.mem_req_wmask = wmask_q;
  assign bus_io.mem_req_size  = size_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-record model checked every cycle,
// directed scenarios with literal expectations, and a small memory responder.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bif ();
  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) u_dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus_io  (bif)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endfunction

  // Memory knobs set by the scenarios.
  int   mem_stall = 0;
  logic mem_err   = 1'b0;

  // Memory: decides on values seen at the falling edge, drives just after the rising edge.
  initial begin : mem_model
    int cnt;
    logic rq, rs, v, r;
    logic [AW-1:0] a;
    cnt = 0;
    bif.mem_req_ready  = 1'b0;
    bif.mem_resp_valid = 1'b0;
    bif.mem_resp_rdata = '0;
    bif.mem_resp_err   = 1'b0;
    forever begin
      @(negedge sys_clk);
      rq = bif.mem_req_valid && bif.mem_req_ready;
      rs = bif.mem_resp_valid && bif.mem_resp_ready;
      v  = bif.mem_req_valid;
      r  = sys_rst;
      a  = bif.mem_req_addr;
      @(posedge sys_clk); #1;
      if (!r) begin
        cnt = 0;
        bif.mem_req_ready  = (mem_stall == 0);
        bif.mem_resp_valid = 1'b0;
        bif.mem_resp_rdata = '0;
        bif.mem_resp_err   = 1'b0;
      end else if (rq) begin
        bif.mem_req_ready  = 1'b0;
        bif.mem_resp_valid = 1'b1;
        bif.mem_resp_rdata = mem_err ? 32'h0 : (a[31] ? 32'h12345678 : 32'h00000013);
        bif.mem_resp_err   = mem_err;
      end else if (rs) begin
        cnt = 0;
        bif.mem_resp_valid = 1'b0;
        bif.mem_resp_rdata = '0;
        bif.mem_resp_err   = 1'b0;
        bif.mem_req_ready  = (mem_stall == 0);
      end else if (!v && !bif.mem_resp_valid) begin
        cnt = 0;
        bif.mem_req_ready = (mem_stall == 0);
      end else if (v && !bif.mem_req_ready) begin
        cnt++;
        if (cnt >= mem_stall) bif.mem_req_ready = 1'b1;
      end
    end
  end

  // Reference model: the in-flight transaction as a record.
  logic          m_on = 1'b0;
  logic          m_busy, m_issued, m_lsu, m_last_lsu;
  logic [AW-1:0] m_addr;
  logic          m_wen;
  logic [DW-1:0] m_wdata;
  logic [3:0]    m_wmask;
  logic [1:0]    m_size;

  always @(posedge sys_clk) begin
    if (!sys_rst) begin
      m_on <= 1'b1; m_busy <= 1'b0; m_issued <= 1'b0; m_lsu <= 1'b0; m_last_lsu <= 1'b1;
      m_addr <= '0; m_wen <= 1'b0; m_wdata <= '0; m_wmask <= '0; m_size <= '0;
    end else if (!m_busy) begin
      if (bif.ifu_req_valid && (!bif.lsu_req_valid || m_last_lsu)) begin
        m_busy <= 1'b1; m_lsu <= 1'b0; m_last_lsu <= 1'b0;
        m_addr <= bif.ifu_req_addr; m_wen <= 1'b0; m_wdata <= '0; m_wmask <= '0; m_size <= 2'd2;
      end else if (bif.lsu_req_valid) begin
        m_busy <= 1'b1; m_lsu <= 1'b1; m_last_lsu <= 1'b1;
        m_addr <= bif.lsu_req_addr; m_wen <= bif.lsu_req_wen; m_wdata <= bif.lsu_req_wdata;
        m_wmask <= bif.lsu_req_wmask; m_size <= bif.lsu_req_size;
      end
    end else if (!m_issued) begin
      if (bif.mem_req_ready) m_issued <= 1'b1;
    end else if (bif.mem_resp_valid && (m_lsu ? bif.lsu_resp_ready : bif.ifu_resp_ready)) begin
      m_busy <= 1'b0; m_issued <= 1'b0;
    end
  end

  always @(negedge sys_clk) begin : cmp
    logic e_irdy, e_lrdy, e_mv, e_iv, e_lv, e_mrr, e_ierr, e_lerr;
    logic [DW-1:0] e_ird, e_lrd;
    e_irdy = 1'b0; e_lrdy = 1'b0; e_mv = 1'b0; e_iv = 1'b0; e_lv = 1'b0; e_mrr = 1'b0;
    e_ierr = 1'b0; e_lerr = 1'b0; e_ird = '0; e_lrd = '0;
    if (m_on) begin
      if (!m_busy) begin
        if (sys_rst) begin
          e_irdy = bif.ifu_req_valid && (!bif.lsu_req_valid || m_last_lsu);
          e_lrdy = bif.lsu_req_valid && !e_irdy;
        end
      end else if (!m_issued) begin
        e_mv = 1'b1;
      end else if (m_lsu) begin
        e_lv = bif.mem_resp_valid; e_lrd = bif.mem_resp_rdata;
        e_lerr = bif.mem_resp_err; e_mrr = bif.lsu_resp_ready;
      end else begin
        e_iv = bif.mem_resp_valid; e_ird = bif.mem_resp_rdata;
        e_ierr = bif.mem_resp_err; e_mrr = bif.ifu_resp_ready;
      end
      chk("m_ifu_req_ready",  bif.ifu_req_ready,  e_irdy);
      chk("m_lsu_req_ready",  bif.lsu_req_ready,  e_lrdy);
      chk("m_mem_req_valid",  bif.mem_req_valid,  e_mv);
      chk("m_mem_req_addr",   bif.mem_req_addr,   m_addr);
      chk("m_mem_req_wen",    bif.mem_req_wen,    m_wen);
      chk("m_mem_req_wdata",  bif.mem_req_wdata,  m_wdata);
      chk("m_mem_req_wmask",  bif.mem_req_wmask,  m_wmask);
      chk("m_mem_req_size",   bif.mem_req_size,   m_size);
      chk("m_mem_resp_ready", bif.mem_resp_ready, e_mrr);
      chk("m_ifu_resp_valid", bif.ifu_resp_valid, e_iv);
      chk("m_ifu_resp_rdata", bif.ifu_resp_rdata, e_ird);
      chk("m_ifu_resp_err",   bif.ifu_resp_err,   e_ierr);
      chk("m_lsu_resp_valid", bif.lsu_resp_valid, e_lv);
      chk("m_lsu_resp_rdata", bif.lsu_resp_rdata, e_lrd);
      chk("m_lsu_resp_err",   bif.lsu_resp_err,   e_lerr);
    end
  end

  task automatic cyc();
    @(posedge sys_clk); #1;
  endtask

  task automatic at_neg();
    @(negedge sys_clk);
  endtask

  // Returns at the falling edge of the cycle in which the client handshake happens.
  task automatic wait_resp(input bit lsu, input string nm, output logic [DW-1:0] rd, output logic er);
    bit done;
    done = 1'b0; rd = '0; er = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      cyc(); at_neg();
      if (lsu ? (bif.lsu_resp_valid && bif.lsu_resp_ready)
              : (bif.ifu_resp_valid && bif.ifu_resp_ready)) begin
        done = 1'b1;
        rd = lsu ? bif.lsu_resp_rdata : bif.ifu_resp_rdata;
        er = lsu ? bif.lsu_resp_err : bif.ifu_resp_err;
      end
    end
    chk({nm, "_resp_seen"}, done, 1);
  endtask

  initial begin : stim
    logic [DW-1:0] rd;
    logic er;
    logic gq[$];
    logic exp_g[4];
    int stall_cyc, rv_cyc;
    bit done;

    bif.ifu_req_valid = 1'b1; bif.ifu_req_addr = 32'h1000; bif.ifu_resp_ready = 1'b1;
    bif.lsu_req_valid = 1'b1; bif.lsu_req_addr = 32'h80000000; bif.lsu_req_wen = 1'b0;
    bif.lsu_req_wdata = '0; bif.lsu_req_wmask = '0; bif.lsu_req_size = 2'd2;
    bif.lsu_resp_ready = 1'b1;

    // Reset held with both clients requesting.
    for (int i = 0; i < 3; i++) begin
      cyc(); at_neg();
      chk("rst_ifu_req_ready", bif.ifu_req_ready, 0);
      chk("rst_lsu_req_ready", bif.lsu_req_ready, 0);
      chk("rst_mem_req_valid", bif.mem_req_valid, 0);
      chk("rst_mem_req_addr",  bif.mem_req_addr,  0);
    end
    cyc(); sys_rst = 1'b1; at_neg();
    chk("t1_ifu_first", bif.ifu_req_ready, 1);
    chk("t1_lsu_lose",  bif.lsu_req_ready, 0);
    cyc(); bif.ifu_req_valid = 1'b0; bif.lsu_req_valid = 1'b0; at_neg();
    chk("t1_mem_valid", bif.mem_req_valid, 1);
    chk("t1_mem_addr",  bif.mem_req_addr,  32'h1000);
    chk("t1_mem_wen",   bif.mem_req_wen,   0);
    chk("t1_mem_size",  bif.mem_req_size,  2);
    wait_resp(1'b0, "t1", rd, er);
    chk("t1_rdata", rd, 32'h13);

    // Single LSU store, zero-wait memory.
    cyc();
    bif.lsu_req_valid = 1'b1; bif.lsu_req_addr = 32'h80000010; bif.lsu_req_wen = 1'b1;
    bif.lsu_req_wdata = 32'hDEADBEEF; bif.lsu_req_wmask = 4'hF; bif.lsu_req_size = 2'd2;
    at_neg();
    chk("t2_lsu_ready", bif.lsu_req_ready, 1);
    cyc(); bif.lsu_req_valid = 1'b0; bif.lsu_req_wen = 1'b0; bif.lsu_req_wdata = '0; at_neg();
    chk("t2_mem_valid", bif.mem_req_valid, 1);
    chk("t2_mem_addr",  bif.mem_req_addr,  32'h80000010);
    chk("t2_mem_wdata", bif.mem_req_wdata, 32'hDEADBEEF);
    chk("t2_mem_wmask", bif.mem_req_wmask, 4'hF);
    chk("t2_mem_wen",   bif.mem_req_wen,   1);
    cyc(); at_neg();
    chk("t2_lsu_resp_valid", bif.lsu_resp_valid, 1);
    chk("t2_ifu_resp_valid", bif.ifu_resp_valid, 0);

    // Round-robin with both clients continuously requesting.
    cyc();
    bif.ifu_req_valid = 1'b1; bif.ifu_req_addr = 32'h100;
    bif.lsu_req_valid = 1'b1; bif.lsu_req_addr = 32'h80000020;
    for (int i = 0; i < 60 && gq.size() < 4; i++) begin
      if (i > 0) cyc();
      at_neg();
      if (bif.ifu_req_ready) gq.push_back(1'b0);
      else if (bif.lsu_req_ready) gq.push_back(1'b1);
      if (bif.ifu_resp_valid) chk("t3_ifu_rdata", bif.ifu_resp_rdata, 32'h00000013);
      if (bif.lsu_resp_valid) chk("t3_lsu_rdata", bif.lsu_resp_rdata, 32'h12345678);
    end
    cyc(); bif.ifu_req_valid = 1'b0; bif.lsu_req_valid = 1'b0;
    at_neg();
    wait_resp(1'b1, "t3", rd, er);
    chk("t3_last_rdata", rd, 32'h12345678);
    exp_g[0] = 1'b0; exp_g[1] = 1'b1; exp_g[2] = 1'b0; exp_g[3] = 1'b1;
    chk("t3_ngrants", gq.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < gq.size()) chk($sformatf("t3_grant%0d", i), gq[i], exp_g[i]);

    // Memory and client backpressure; IFU waits behind the LSU transaction.
    cyc();
    mem_stall = 5; bif.lsu_resp_ready = 1'b0;
    bif.lsu_req_valid = 1'b1; bif.lsu_req_addr = 32'h80000040;
    at_neg();
    chk("t4_lsu_ready", bif.lsu_req_ready, 1);
    cyc(); bif.lsu_req_valid = 1'b0; bif.ifu_req_valid = 1'b1; bif.ifu_req_addr = 32'h200;
    stall_cyc = 0; rv_cyc = 0; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (i > 0) cyc();
      if (rv_cyc == 3) bif.lsu_resp_ready = 1'b1;
      at_neg();
      chk("t4_addr_stable", bif.mem_req_addr, 32'h80000040);
      chk("t4_no_accept", bif.ifu_req_ready, 0);
      if (bif.mem_req_valid && !bif.mem_req_ready) stall_cyc++;
      if (bif.lsu_resp_valid) begin
        mem_stall = 0;
        chk("t4_mrr_mirror", bif.mem_resp_ready, bif.lsu_resp_ready);
        if (!bif.lsu_resp_ready) rv_cyc++;
        else done = 1'b1;
      end
    end
    chk("t4_done", done, 1);
    chk("t4_req_stall", stall_cyc, 5);
    chk("t4_resp_stall", rv_cyc, 3);
    cyc(); at_neg();
    chk("t4_ifu_accept", bif.ifu_req_ready, 1);
    cyc(); bif.ifu_req_valid = 1'b0;
    wait_resp(1'b0, "t4", rd, er);

    // Error response, then a clean one.
    cyc(); mem_err = 1'b1; bif.ifu_req_valid = 1'b1; bif.ifu_req_addr = 32'h300; at_neg();
    chk("t5_accept", bif.ifu_req_ready, 1);
    cyc(); bif.ifu_req_valid = 1'b0;
    wait_resp(1'b0, "t5", rd, er);
    chk("t5_err", er, 1);
    chk("t5_rdata", rd, 0);
    cyc(); mem_err = 1'b0; bif.ifu_req_valid = 1'b1; bif.ifu_req_addr = 32'h304; at_neg();
    cyc(); bif.ifu_req_valid = 1'b0;
    wait_resp(1'b0, "t5b", rd, er);
    chk("t5b_err", er, 0);
    chk("t5b_rdata", rd, 32'h13);

    // Reset while a response is pending.
    cyc(); bif.ifu_resp_ready = 1'b0; bif.ifu_req_valid = 1'b1; bif.ifu_req_addr = 32'h400; at_neg();
    cyc(); bif.ifu_req_valid = 1'b0; at_neg();
    cyc(); at_neg();
    chk("t6_pending", bif.ifu_resp_valid, 1);
    cyc(); sys_rst = 1'b0; at_neg();
    cyc(); sys_rst = 1'b1; bif.ifu_resp_ready = 1'b1;
    bif.ifu_req_valid = 1'b1; bif.ifu_req_addr = 32'h500;
    bif.lsu_req_valid = 1'b1; bif.lsu_req_addr = 32'h80000050;
    at_neg();
    chk("t6_ifu_resp_valid", bif.ifu_resp_valid, 0);
    chk("t6_lsu_resp_valid", bif.lsu_resp_valid, 0);
    chk("t6_mem_req_valid",  bif.mem_req_valid,  0);
    chk("t6_ifu_wins",       bif.ifu_req_ready,  1);
    chk("t6_lsu_loses",      bif.lsu_req_ready,  0);
    cyc(); bif.ifu_req_valid = 1'b0; bif.lsu_req_valid = 1'b0;
    wait_resp(1'b0, "t6", rd, er);
    chk("t6_rdata", rd, 32'h13);

    cyc(); at_neg();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
